// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for the modified JK flip-flop: buffers hold/reset/set/toggle commands,
// replays them as registered en/J/K drive and checks the fed-back q against a reference model.
// Optional build macro JK_CMD_STATS_EN adds a saturating completed-command counter (cmd_done_cnt).
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             cmd_ready,
  input  logic             clr_req,
  output logic             en,
  output logic             J,
  output logic             K,
  output logic             preset,
  output logic             prereset,
  input  logic             q_in,
  output logic             q_exp,
  output logic             q_known,
  output logic             mismatch,
  output logic             busy
`ifdef JK_CMD_STATS_EN
  ,
  output logic [15:0]      cmd_done_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CLR = 2'd2} state_t;

  state_t           state_q, ret_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       op_q;
  logic             en_q, j_q, k_q, prereset_q;
  logic             q_exp_q, q_known_q, mismatch_q;

  logic             empty, full, push, fetch, finish;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_rep, head_rem;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_op   = head[EW-1:CNT_W];
  assign head_rep  = head[CNT_W-1:0];
  assign head_rem  = (head_rep == '0) ? CNT_W'(1) : head_rep;

  // A clear cycle never consumes or completes a command; it only pauses it.
  assign finish = !clr_req && (state_q == ISSUE) && (rem_q == CNT_W'(1));
  assign fetch  = !clr_req && !empty &&
                  ((state_q == IDLE) || finish || ((state_q == CLR) && (ret_q == IDLE)));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_rep};
  end

  always_ff @(posedge clk) begin
    if (rst)       wr_ptr_q <= '0;
    else if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      op_q       <= 2'b00;
      en_q       <= 1'b0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      prereset_q <= 1'b1;
      q_exp_q    <= 1'b0;
      q_known_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      // Reference model tracks what the flip-flop does with this cycle's drive.
      if (!prereset_q) begin
        q_exp_q   <= 1'b0;
        q_known_q <= 1'b1;
      end else if (en_q) begin
        case ({j_q, k_q})
          2'b01:   begin q_exp_q <= 1'b0; q_known_q <= 1'b1; end
          2'b10:   begin q_exp_q <= 1'b1; q_known_q <= 1'b1; end
          2'b11:   q_exp_q <= ~q_exp_q;
          default: ;
        endcase
      end
      if (q_known_q && (q_in != q_exp_q)) mismatch_q <= 1'b1;

      prereset_q <= 1'b1;
      if (clr_req) begin
        if (state_q != CLR) ret_q <= state_q;
        state_q    <= CLR;
        en_q       <= 1'b0;
        j_q        <= 1'b0;
        k_q        <= 1'b0;
        prereset_q <= 1'b0;
      end else if (fetch) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        state_q  <= ISSUE;
        op_q     <= head_op;
        rem_q    <= head_rem;
        en_q     <= 1'b1;
        j_q      <= head_op[1];
        k_q      <= head_op[0];
      end else begin
        case (state_q)
          ISSUE: begin
            if (rem_q == CNT_W'(1)) begin
              state_q <= IDLE;
              en_q    <= 1'b0;
              j_q     <= 1'b0;
              k_q     <= 1'b0;
            end else begin
              rem_q <= rem_q - CNT_W'(1);
            end
          end
          CLR: begin
            if (ret_q == ISSUE) begin
              state_q <= ISSUE;
              en_q    <= 1'b1;
              j_q     <= op_q[1];
              k_q     <= op_q[0];
            end else begin
              state_q <= IDLE;
              en_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JK_CMD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                    cmd_done_cnt <= 16'd0;
    else if (finish && (cmd_done_cnt != 16'hFFFF)) cmd_done_cnt <= cmd_done_cnt + 16'd1;
  end
`endif

  assign en       = en_q;
  assign J        = j_q;
  assign K        = k_q;
  assign preset   = 1'b1;
  assign prereset = prereset_q;
  assign q_exp    = q_exp_q;
  assign q_known  = q_known_q;
  assign mismatch = mismatch_q;
  assign busy     = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios plus random traffic against a queue-based
// cycle model of the command stream, flip-flop behaviour and compare flag.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             clr_req = 1'b0;
  logic             q_in = 1'b0;
  logic             cmd_ready, en, J, K, preset, prereset, q_exp, q_known, mismatch, busy;
`ifdef JK_CMD_STATS_EN
  logic [15:0]      cmd_done_cnt;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_rep(cmd_rep),
    .cmd_ready(cmd_ready), .clr_req(clr_req), .en(en), .J(J), .K(K), .preset(preset),
    .prereset(prereset), .q_in(q_in), .q_exp(q_exp), .q_known(q_known),
    .mismatch(mismatch), .busy(busy)
`ifdef JK_CMD_STATS_EN
    , .cmd_done_cnt(cmd_done_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit q_follow = 1'b1;

  // Reference model: pending commands, remaining cycles of the active one, expected outputs.
  logic [CNT_W+1:0] m_fifo[$];
  int       m_rem = 0;
  int       m_done = 0;
  logic [1:0] m_op = 2'b00;
  bit m_en = 0, m_j = 0, m_k = 0, m_pre = 1, m_qexp = 0, m_known = 0, m_mis = 0;

  function automatic logic [9:0] dut_vec();
    return {en, J, K, preset, prereset, cmd_ready, busy, q_exp, q_known, mismatch};
  endfunction

  function automatic logic [9:0] model_vec();
    bit rdy, bsy;
    rdy = (m_fifo.size() < DEPTH);
    bsy = (m_fifo.size() > 0) || (m_rem > 0) || !m_pre;
    return {m_en, m_j, m_k, 1'b1, m_pre, rdy, bsy, m_qexp, m_known, m_mis};
  endfunction

  // Advance DUT and model by one clock with the currently driven inputs.
  task automatic step();
    bit n_en, n_j, n_k, n_pre, n_qexp, n_known, n_mis, accepted;
    logic [CNT_W+1:0] e;
    if (q_follow) q_in = m_qexp;
    if (rst) begin
      m_fifo.delete();
      m_rem = 0; m_done = 0; m_op = 2'b00;
      n_en = 0; n_j = 0; n_k = 0; n_pre = 1; n_qexp = 0; n_known = 0; n_mis = 0;
    end else begin
      n_qexp = m_qexp; n_known = m_known; n_mis = m_mis;
      if (m_known && (q_in !== m_qexp)) n_mis = 1;
      if (!m_pre) begin
        n_qexp = 0; n_known = 1;
      end else if (m_en) begin
        if ({m_j, m_k} == 2'b01)      begin n_qexp = 0; n_known = 1; end
        else if ({m_j, m_k} == 2'b10) begin n_qexp = 1; n_known = 1; end
        else if ({m_j, m_k} == 2'b11) n_qexp = ~m_qexp;
      end
      accepted = cmd_valid && (m_fifo.size() < DEPTH);
      if (clr_req) begin
        n_en = 0; n_j = 0; n_k = 0; n_pre = 0;
      end else begin
        n_pre = 1;
        if (m_rem > 0 && m_pre) begin
          m_rem--;
          if (m_rem == 0 && m_done < 65535) m_done++;
        end
        if (m_rem == 0 && m_fifo.size() > 0) begin
          e = m_fifo.pop_front();
          m_op = e[CNT_W+1:CNT_W];
          m_rem = (e[CNT_W-1:0] == 0) ? 1 : int'(e[CNT_W-1:0]);
        end
        if (m_rem > 0) begin n_en = 1; n_j = m_op[1]; n_k = m_op[0]; end
        else begin n_en = 0; n_j = 0; n_k = 0; end
      end
      if (accepted) m_fifo.push_back({cmd_op, cmd_rep});
    end
    @(posedge clk);
    #1;
    m_en = n_en; m_j = n_j; m_k = n_k; m_pre = n_pre;
    m_qexp = n_qexp; m_known = n_known; m_mis = n_mis;
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    // en J K preset prereset ready busy q_exp q_known mismatch
    exp_v = 10'b000_1_1_1_0_0_0_0;
    n_checks++;
    if (dut_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state got %b exp %b", dut_vec(), exp_v);
    end
  endtask

  task automatic test_clear();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n_checks++;
    if ({prereset, en} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_pulse prereset/en got %b exp 00", {prereset, en});
    end
    step();
    n_checks++;
    if ({prereset, q_exp, q_known} !== 3'b101) begin
      n_fail++;
      $display("FAIL clear_after prereset/q_exp/q_known got %b exp 101", {prereset, q_exp, q_known});
    end
  endtask

  task automatic test_back_to_back();
    bit       en_e [4] = '{1, 1, 1, 0};
    bit [1:0] jk_e [4] = '{2'b11, 2'b11, 2'b11, 2'b00};
    bit       qx_e [4] = '{1, 0, 1, 0};
    bit       bz_e [4] = '{1, 1, 1, 0};
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rep = 4'd1;
    step();
    n_checks++;
    if (en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_latency en got %b exp 0", en);
    end
    cmd_op = 2'b11; cmd_rep = 4'd3;
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if ({en, J, K} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_first en/J/K got %b exp 110", {en, J, K});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({en, J, K, q_exp, busy} !== {en_e[i], jk_e[i], qx_e[i], bz_e[i]}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d en/J/K/q_exp/busy got %b exp %b", i,
                 {en, J, K, q_exp, busy}, {en_e[i], jk_e[i], qx_e[i], bz_e[i]});
      end
    end
  endtask

  task automatic test_mismatch();
    q_follow = 1'b0;
    q_in = 1'b1;
    step();
    q_follow = 1'b1;
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_set got %b exp 1", mismatch);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_sticky got %b exp 1", mismatch);
    end
  endtask

  task automatic test_fifo_full();
    int en_cycles = 0;
    int guard = 0;
    clr_req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_push%0d ready got %b exp 1", i, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = 2'($urandom_range(3)); cmd_rep = 4'd2;
      step();
    end
    cmd_op = 2'($urandom_range(3));
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall%0d ready got %b exp 0", i, cmd_ready);
      end
      step();
    end
    clr_req = 1'b0;
    step();
    n_checks++;
    if ({cmd_ready, en} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_first_pop ready/en got %b exp 11", {cmd_ready, en});
    end
    en_cycles += int'(en);
    step();
    cmd_valid = 1'b0;
    en_cycles += int'(en);
    while (busy === 1'b1 && guard < 40) begin
      step();
      guard++;
      en_cycles += int'(en);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL full_drain got %b exp %b", dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b0 || en_cycles != 10) begin
      n_fail++;
      $display("FAIL full_total busy=%b en_cycles=%0d exp busy=0 en_cycles=10", busy, en_cycles);
    end
  endtask

  task automatic test_rst_mid();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rep = 4'd8;
    step();
    cmd_op = 2'b10; cmd_rep = 4'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({en, busy, cmd_ready, q_known, mismatch} !== 5'b00100) begin
      n_fail++;
      $display("FAIL rst_mid en/busy/ready/q_known/mismatch got %b exp 00100",
               {en, busy, cmd_ready, q_known, mismatch});
    end
`ifdef JK_CMD_STATS_EN
    n_checks++;
    if (cmd_done_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cnt got %0d exp 0", cmd_done_cnt);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({en, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_mid_flushed%0d en/busy got %b exp 00", i, {en, busy});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cmd_valid = ($urandom_range(1) == 1);
      cmd_op    = 2'($urandom_range(3));
      cmd_rep   = ($urandom_range(7) == 0) ? CNT_W'($urandom_range(15)) : CNT_W'($urandom_range(3));
      clr_req   = ($urandom_range(15) == 0);
      step();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_c%0d got %b exp %b", i, dut_vec(), model_vec());
      end
`ifdef JK_CMD_STATS_EN
      n_checks++;
      if (cmd_done_cnt !== 16'(m_done)) begin
        n_fail++;
        $display("FAIL random_cnt_c%0d got %0d exp %0d", i, cmd_done_cnt, m_done);
      end
`endif
    end
    cmd_valid = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_clear();
    test_back_to_back();
    test_mismatch();
    test_fifo_full();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
